// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with pipeline stall and one-cycle ack
// Optional one-entry load fast-hit buffer enabled by defining DMEM_FASTHIT_EN.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [3:0]       counter;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_misalign;
    logic             lat_read;
    logic             lat_write;
    logic [31:0]      lat_wdata;
    logic [31:0]      mem [DEPTH];

    logic             req;
    logic [IDX_W-1:0] req_idx;
    logic             req_misalign;
    logic             access_now;
    logic             hit;
    logic             unused_addr;

    assign req          = MemRead_i | MemWrite_i;
    assign req_idx      = addr_i[ADDR_W-1:2];
    assign req_misalign = |addr_i[1:0];
    assign access_now   = (state == S_WAIT) && (counter == 4'd0);
    assign unused_addr  = ^addr_i[31:ADDR_W];

    assign stall_o = ((state == S_IDLE) && req) || (state == S_WAIT);
    assign ack_o   = (state == S_DONE);
    assign err_o   = (state == S_DONE) && lat_misalign;

`ifdef DMEM_FASTHIT_EN
    logic             buf_valid;
    logic [IDX_W-1:0] buf_idx;
    logic [31:0]      buf_data;

    // Write-through on every completed access keeps the single entry coherent with mem.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_data  <= '0;
        end else if (access_now) begin
            buf_valid <= 1'b1;
            buf_idx   <= lat_idx;
            buf_data  <= lat_write ? lat_wdata : mem[lat_idx];
        end
    end

    assign hit = MemRead_i && !MemWrite_i && buf_valid && (buf_idx == req_idx);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            counter      <= 4'd0;
            rdata_o      <= '0;
            lat_idx      <= '0;
            lat_misalign <= 1'b0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            lat_wdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_idx      <= req_idx;
                        lat_misalign <= req_misalign;
                        lat_read     <= MemRead_i;
                        lat_write    <= MemWrite_i;
                        lat_wdata    <= wdata_i;
                        if (hit) begin
`ifdef DMEM_FASTHIT_EN
                            rdata_o <= buf_data;
`endif
                            state   <= S_DONE;
                        end else begin
                            counter <= LAT_M1;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (counter == 4'd0) begin
                        // A combined read+write behaves as a store that echoes its data.
                        if (!lat_write) begin
                            rdata_o <= mem[lat_idx];
                        end else if (lat_read) begin
                            rdata_o <= lat_wdata;
                        end
                        state <= S_DONE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (access_now && lat_write) begin
            mem[lat_idx] <= lat_wdata;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (also built with DMEM_FASTHIT_EN)
module tb_dmem_responder;
    localparam int LAT = 4;
    localparam int AW  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        ack;
    logic        err;

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .MemRead_i (mem_read),
        .MemWrite_i(mem_write),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rdata_o   (rdata),
        .stall_o   (stall),
        .ack_o     (ack),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] mem_m [int];
    logic [31:0] last_rdata = 32'h0;
    bit          buf_v = 1'b0;
    int          buf_idx = 0;
    int          stall_cnt = 0;
    bit          prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and checks each ack against the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
            prev_ack  = 1'b0;
        end else begin
            if (prev_ack) chk("ack_one_cycle", 32'(ack), 32'h0);
            if (ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_ack: ack with empty scoreboard, rdata %h", rdata);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rdata", rdata, mon_e.rdata);
                    chk("err", 32'(err), 32'(mon_e.err));
                    chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stalls));
                end
                stall_cnt = 0;
            end else if (stall) begin
                stall_cnt++;
            end
            prev_ack = ack;
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   idx;
        int   n;
        bit   got;
        @(posedge clk);
        #1;
        chk("idle_stall", 32'(stall), 32'h0);
        chk("idle_ack", 32'(ack), 32'h0);
        idx      = int'(a[AW-1:2]);
        e.err    = (a[1:0] != 2'b00);
        e.stalls = LAT + 1;
`ifdef DMEM_FASTHIT_EN
        if (rd && !wr && buf_v && buf_idx == idx) e.stalls = 1;
`endif
        if (wr) begin
            mem_m[idx] = wd;
            if (rd) last_rdata = wd;
        end else begin
            last_rdata = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        end
        e.rdata = last_rdata;
        buf_v   = 1'b1;
        buf_idx = idx;
        sb.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                mem_read  = 1'($urandom);
                mem_write = 1'($urandom);
                addr      = $urandom;
                wdata     = $urandom;
                n++;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL ack_timeout: no ack within 64 cycles for addr %h", a);
            sb.delete();
        end
    endtask

    task automatic aborted_store(input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        addr      = $urandom;
        @(posedge clk);
        #1;
        chk("abort_wait_stall", 32'(stall), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(stall), 32'h0);
        chk("async_rst_ack", 32'(ack), 32'h0);
        chk("async_rst_err", 32'(err), 32'h0);
        chk("async_rst_rdata", rdata, 32'h0);
        last_rdata = 32'h0;
        buf_v      = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        access(1'b0, 1'b1, 32'h010, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h010, 32'h0);
        access(1'b1, 1'b0, 32'h013, 32'h0);
        access(1'b1, 1'b0, 32'h410, 32'h0);
        access(1'b0, 1'b1, 32'h020, 32'h11111111);
        aborted_store(32'h020, 32'h00000055);
        access(1'b1, 1'b0, 32'h020, 32'h0);
        access(1'b1, 1'b1, 32'h030, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'h030, 32'h0);
`ifdef DMEM_FASTHIT_EN
        access(1'b0, 1'b1, 32'h014, 32'h01234567);
        access(1'b1, 1'b0, 32'h010, 32'h0);
        access(1'b1, 1'b0, 32'h010, 32'h0);
        access(1'b1, 1'b0, 32'h014, 32'h0);
`endif

        for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 32'(i << 2), $urandom);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            a[AW-1:2] = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            op = $urandom_range(0, 4);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if (op <= 2) access(1'b1, 1'b0, a, 32'h0);
            else if (op == 3) access(1'b0, 1'b1, a, $urandom);
            else access(1'b1, 1'b1, a, $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests.
- Replaces the single-cycle data memory. Models a slow backing store with a fixed access latency.
- Drives a stall back to the pipeline, which freezes all stages while an access is outstanding.
- Completes each access with a one-cycle acknowledge carrying read data.

Parameters:
- ADDR_W, 10, byte-address bits decoded; upper request address bits are ignored.
- LATENCY, 4, wait cycles per access; legal range 1..15.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- MemRead_i  in  1  load request from EX/MEM.
- MemWrite_i  in  1  store request from EX/MEM.
- addr_i  in  32  byte address (ALU result).
- wdata_i  in  32  store data.
- rdata_o  out  32  load data, valid while ack_o=1, held until next completion.
- stall_o  out  1  freeze pipeline; combinational.
- ack_o  out  1  one-cycle access-complete pulse.
- err_o  out  1  pulses with ack_o when addr_i[1:0]!=0.

Behaviour:
- Reset (asynchronous, rst_i=1): state=IDLE, counter=0, rdata_o=0, ack_o=0, err_o=0, stall_o=0.
- Reset mid-operation: a pending store is discarded. The memory array is never cleared by reset.
- Storage: 2^(ADDR_W-2) words, indexed by addr[ADDR_W-1:2].
  - Addresses alias (wrap) above ADDR_W bits.
  - Misaligned addresses access the truncated word and raise err_o with ack_o.
- State IDLE:
  - If MemRead_i|MemWrite_i: stall_o=1 combinationally in the same cycle.
  - Latch addr_i, wdata_i, request type; counter<=LATENCY-1; go WAIT.
  - Otherwise stay IDLE with stall_o=0.
- State WAIT:
  - stall_o=1; counter decrements each cycle.
  - At the edge where counter==0: perform the access, then go DONE.
    - Store: write latched data.
    - Load: rdata_o <= mem[index].
- State DONE:
  - stall_o=0, ack_o=1, err_o per latched address; the pipeline advances at this edge.
  - Next state is IDLE, unconditionally.
  - Requests present during DONE are ignored; they belong to the departing instruction.
- Latency: request first seen in IDLE at cycle T.
  - stall_o=1 for cycles T..T+LATENCY.
  - ack_o=1 in cycle T+LATENCY+1.
  - Earliest next request is accepted at T+LATENCY+2.
- MemRead_i and MemWrite_i both asserted: treated as a store; rdata_o <= wdata at completion.
- Requests are latched in IDLE. Input changes during WAIT have no effect.
- rdata_o is registered and retains its value across stores and idle cycles; only loads update it.

Optional Feature:
- Macro: DMEM_FASTHIT_EN.
- With the macro defined: a one-entry buffer holds tag and data of the last completed access, plus a valid bit.
  - Valid bit is cleared by reset.
  - A load in IDLE whose word index matches a valid buffer skips WAIT and goes directly to DONE.
  - On a hit, stall_o=1 only in cycle T; ack_o in T+1 with the buffered data.
  - Stores always take the full latency and update the buffer (write-through).
  - Misaligned hits still raise err_o.
- Without the macro: no buffer; every access takes LATENCY wait cycles.

Test Plan:
- Reset, idle inputs → stall_o=0, ack_o=0, err_o=0, rdata_o=0. Assert rst_i mid-cycle → outputs clear immediately without a clock edge.
- Store 0xDEADBEEF to 0x010 at cycle T, LATENCY=4 → stall_o=1 for T..T+4, ack_o at T+5. Then load 0x010 → rdata_o=0xDEADBEEF at its ack, stall lasting 5 cycles.
- Load 0x013 after the previous store → ack with err_o=1, rdata_o=0xDEADBEEF. Load 0x410 (ADDR_W=10) → aliases to 0x010, returns 0xDEADBEEF, err_o=0.
- Setup: 0x020 holds 0x11111111. Store 0x00000055 to 0x020, assert rst_i during the second WAIT cycle → stall_o drops asynchronously, no ack. Later load 0x020 → 0x11111111.
- MemRead_i=MemWrite_i=1, addr 0x030, wdata 0xA5A5A5A5 → store performed, rdata_o=0xA5A5A5A5 at ack. Subsequent load 0x030 → 0xA5A5A5A5.
- DMEM_FASTHIT_EN: load 0x010 (miss, ack at T+5), then load 0x010 → ack at T'+1, data 0xDEADBEEF. Then load 0x014 → miss, full latency.
